// File: rtl/modinv_pkg.sv
// Shared types for the modular-inverse engine: Gray-coded FSM states and handshake notes.
package modinv_pkg;

  localparam int unsigned ST_W = 3;

  // Handshake: any toggle on req starts an operation; ack is high exactly
  // while the FSM sits in st_idle, so a falling ack acknowledges the start
  // and a rising ack marks a valid result on tx_data/tx_ok.

  // State codes are the 3-bit Gray code of 0..5 (X ^ (X >> 1)).
  typedef enum logic [ST_W-1:0] {
    st_idle = 3'b000,
    st_load = 3'b001,
    st_test = 3'b011,
    st_sub  = 3'b010,
    st_swap = 3'b110,
    st_done = 3'b111
  } state_e;

  // Gray encoding helper, kept next to the state table it generates.
  function automatic logic [ST_W-1:0] gray(input logic [ST_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/modinv_modsub.sv
// Combinational modular subtract: z = (x - y) mod n for x, y already in [0, n).
module modsub #(
  parameter int unsigned MSB = 7
) (
  input  logic [MSB:0] x,
  input  logic [MSB:0] y,
  input  logic [MSB:0] n,
  output logic [MSB:0] z
);

  localparam int unsigned W = MSB + 1;

  logic [W:0] xe;
  logic [W:0] ye;
  logic [W:0] ne;

  // One extra bit so x + n cannot wrap before y is removed.
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  assign ne = {1'b0, n};

  // Wrap through n only when the plain difference would go negative.
  assign z = (x >= y) ? W'(xe - ye) : W'(xe + ne - ye);

endmodule

// File: rtl/modinv.sv
// Modular-inverse engine: d = e^-1 mod phi by subtraction-based extended Euclid.
module modinv
  import modinv_pkg::*;
#(
  parameter int unsigned MSB = 7
) (
  input  logic           rstn,
  input  logic           clk0,
  input  logic           enable,
  input  logic           req,
  output logic           ack,
  output logic [2:0]     cst,
  output logic [2:0]     nst,
  input  logic [MSB:0]   rx_data_1,
  input  logic [MSB:0]   rx_data_2,
  output logic [MSB:0]   tx_data,
  output logic           tx_ok
);

  localparam int unsigned W = MSB + 1;

  state_e         cs;
  state_e         ns;
  logic           req_d;
  logic           req_x;
  logic [W-1:0]   old_r;
  logic [W-1:0]   r;
  logic [W-1:0]   old_t;
  logic [W-1:0]   t;
  logic [W-1:0]   phi_reg;
  logic [W-1:0]   diff;
  logic [W-1:0]   t_sub;
  logic           ok_next;

  assign req_x   = req ^ req_d;
  assign diff    = old_r - r;
  assign ok_next = (old_r == W'(1)) && (phi_reg >= W'(2));

  assign ack = (cs == st_idle);
  assign cst = cs;
  assign nst = ns;

  // Coefficient update keeps old_t reduced into [0, phi).
  modsub #(.MSB(MSB)) u_modsub (
    .x (old_t),
    .y (t),
    .n (phi_reg),
    .z (t_sub)
  );

  // Next-state decode; sub repeats while another subtraction of r still fits.
  always_comb begin
    ns = st_idle;
    case (cs)
      st_idle: ns = req_x ? st_load : st_idle;
      st_load: ns = (rx_data_2 < W'(2)) ? st_done : st_test;
      st_test: begin
        if (r == '0) begin
          ns = st_done;
        end else if (old_r >= r) begin
          ns = st_sub;
        end else begin
          ns = st_swap;
        end
      end
      st_sub:  ns = (diff >= r) ? st_sub : st_swap;
      st_swap: ns = st_test;
      st_done: ns = st_idle;
      default: ns = st_idle;
    endcase
  end

  // State, request edge detector and Euclid datapath; each state's work
  // is committed on the edge that leaves it, everything frozen when enable is low.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      cs      <= st_idle;
      req_d   <= 1'b0;
      old_r   <= '0;
      r       <= '0;
      old_t   <= '0;
      t       <= '0;
      phi_reg <= '0;
      tx_data <= '0;
      tx_ok   <= 1'b0;
    end else if (enable) begin
      cs    <= ns;
      req_d <= req;
      case (cs)
        st_load: begin
          old_r   <= rx_data_2;
          r       <= rx_data_1;
          old_t   <= '0;
          t       <= W'(1);
          phi_reg <= rx_data_2;
        end
        st_sub: begin
          old_r <= diff;
          old_t <= t_sub;
        end
        st_swap: begin
          old_r <= r;
          r     <= old_r;
          old_t <= t;
          t     <= old_t;
        end
        st_done: begin
          tx_ok   <= ok_next;
          tx_data <= ok_next ? old_t : '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
